// File: rtl/fifo_uart_tx_drain_pkg.sv
// Shared constants for the FIFO-draining UART transmitter: FSM state codes
// and parity-type encodings.
package fifo_uart_tx_drain_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_drain_bit_timer.sv
// Per-bit cycle counter: counts 0..P-1 while a frame is active and flags the
// last cycle of each bit so the transmitter FSM knows when to advance.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_run,
  input  logic [PRESCALE_WIDTH-1:0] i_p,
  output logic                      o_bit_done
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] r_cnt;

  assign o_bit_done = i_run && (r_cnt == (i_p - ONE));

  // Held at zero while idle so the first bit of a frame gets its full P cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || o_bit_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/fifo_uart_tx_drain.sv
// Read-side FIFO consumer: pops one word when allowed and serialises it as a
// UART frame (start, data LSB first, optional parity, stop) on TX_OUT.
module fifo_uart_tx_drain
  import fifo_uart_tx_drain_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0]     FIFO_RD_DATA,
  output logic                      FIFO_R_INC,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY
);

  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
  localparam logic [PRESCALE_WIDTH-1:0] P_ONE    = PRESCALE_WIDTH'(1);

  logic [2:0]                r_state;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_par_en;
  logic                      r_parity;
  logic [PRESCALE_WIDTH-1:0] r_p;
  logic [IDX_W-1:0]          r_bit_idx;
  logic                      r_tx;
  logic                      r_busy;
  logic                      r_r_inc;
  logic                      w_run;
  logic                      w_bit_done;

  assign w_run = (r_state != S_IDLE);

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_run      (w_run),
    .i_p        (r_p),
    .o_bit_done (w_bit_done)
  );

  assign FIFO_R_INC = r_r_inc;
  assign TX_OUT     = r_tx;
  assign BUSY       = r_busy;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_parity  <= 1'b0;
      r_p       <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_r_inc   <= 1'b0;
    end else begin
      r_r_inc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (EN && !FIFO_EMPTY) begin
            r_shift  <= FIFO_RD_DATA;
            r_par_en <= PAR_EN;
            // PAR_TYP is folded into the parity bit here, while the whole word is at hand.
            r_parity <= (^FIFO_RD_DATA) ^ (PAR_TYP == PAR_ODD);
            r_p      <= (PRESCALE == '0) ? P_ONE : PRESCALE;
            r_r_inc  <= 1'b1;
            r_busy   <= 1'b1;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            if (r_bit_idx == LAST_IDX) begin
              r_tx    <= r_par_en ? r_parity : 1'b1;
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[DATA_WIDTH-1:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + IDX_ONE;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_done) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: behavioural FIFO on the read side, expected
// frames queued at push time and compared as frames are received on TX_OUT.
`timescale 1ns/1ps
module tb_fifo_uart_tx_drain;
  import fifo_uart_tx_drain_pkg::*;

  logic       CLK = 1'b0;
  logic       WCLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic       FIFO_EMPTY;
  logic [7:0] FIFO_RD_DATA;
  logic       FIFO_R_INC;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] PRESCALE = 6'd1;
  logic       TX_OUT;
  logic       BUSY;

  int errors = 0;
  int checks = 0;
  int pop_count = 0;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    int         p;
  } exp_t;
  exp_t sb[$];

  logic [7:0] fifo_mem [8];
  logic [3:0] wptr = 4'd0;
  logic [3:0] rptr = 4'd0;

  always #5 CLK = ~CLK;
  always #7 WCLK = ~WCLK;

  assign FIFO_EMPTY   = (wptr == rptr);
  assign FIFO_RD_DATA = fifo_mem[rptr[2:0]];

  always @(posedge CLK) begin
    if (FIFO_R_INC && !FIFO_EMPTY) rptr <= rptr + 4'd1;
    if (FIFO_R_INC) pop_count <= pop_count + 1;
  end

  fifo_uart_tx_drain #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_R_INC(FIFO_R_INC), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .BUSY(BUSY)
  );

  task automatic push_word(input logic [7:0] d, input logic pe, input logic pt, input int p);
    exp_t e;
    fifo_mem[wptr[2:0]] = d;
    wptr = wptr + 4'd1;
    e.data = d; e.par_en = pe; e.par_typ = pt; e.p = p;
    sb.push_back(e);
  endtask

  function automatic logic [11:0] exp_bits(input exp_t e);
    logic [11:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[1+i] = e.data[i];
    if (e.par_en) begin
      b[9]  = (^e.data) ^ e.par_typ;
      b[10] = 1'b1;
    end else begin
      b[9] = 1'b1;
    end
    return b;
  endfunction

  // Waits for a start bit, then samples every cycle of every bit.
  task automatic rx_frame(input int p, input int nbits, output logic [11:0] bits,
                          output bit shape_ok, output int wait_cnt);
    logic v;
    bits = '0; shape_ok = 1'b1; wait_cnt = 0;
    @(negedge CLK);
    while (TX_OUT !== 1'b0 && wait_cnt < 600) begin
      @(negedge CLK);
      wait_cnt++;
    end
    if (wait_cnt >= 600) return;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < p; c++) begin
        if (k != 0 || c != 0) @(negedge CLK);
        v = TX_OUT;
        if (c == 0) bits[k] = v;
        else if (v !== bits[k]) shape_ok = 1'b0;
        if (BUSY !== 1'b1) shape_ok = 1'b0;
        if (FIFO_R_INC !== ((k == 0 && c == 0) ? 1'b1 : 1'b0)) shape_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int p0;
    @(negedge CLK);
    checks++;
    if ({TX_OUT, BUSY, FIFO_R_INC} !== 3'b100) begin
      errors++; $display("FAIL reset_init: got %b want 100", {TX_OUT, BUSY, FIFO_R_INC});
    end
    RST = 1'b1;
    EN = 1'b1; PAR_EN = 1'b0; PRESCALE = 6'd4;
    fifo_mem[wptr[2:0]] = 8'hC3;
    wptr = wptr + 4'd1;
    repeat (12) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL reset_frame_active: BUSY=%b want 1", BUSY);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({TX_OUT, BUSY, FIFO_R_INC} !== 3'b100) begin
      errors++; $display("FAIL reset_midframe: got %b want 100", {TX_OUT, BUSY, FIFO_R_INC});
    end
    @(negedge CLK);
    RST = 1'b1;
    p0 = pop_count;
    repeat (20) @(negedge CLK);
    checks++;
    if ({pop_count - p0, 32'(TX_OUT), 32'(BUSY)} !== {32'd0, 32'd1, 32'd0}) begin
      errors++; $display("FAIL reset_release: pops=%0d tx=%b busy=%b want 0,1,0", pop_count - p0, TX_OUT, BUSY);
    end
  endtask

  task automatic test_single();
    logic [11:0] bits; bit shape; int w; int p0; exp_t e;
    EN = 1'b1; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN; PRESCALE = 6'd4;
    p0 = pop_count;
    push_word(8'hA5, 1'b0, PAR_EVEN, 4);
    rx_frame(4, 10, bits, shape, w);
    e = sb.pop_front();
    checks++;
    if (w >= 600) begin errors++; $display("FAIL single_timeout: waited %0d cycles", w); end
    checks++;
    if (bits[9:0] !== 10'b1101001010) begin
      errors++; $display("FAIL single_bits: got %b want 1101001010", bits[9:0]);
    end
    checks++;
    if (bits !== exp_bits(e)) begin errors++; $display("FAIL single_model: got %h want %h", bits, exp_bits(e)); end
    checks++;
    if (!shape) begin errors++; $display("FAIL single_shape: bit hold/BUSY/R_INC wrong, got 0 want 1"); end
    @(negedge CLK);
    checks++;
    if ({TX_OUT, BUSY} !== 2'b10 || pop_count - p0 != 1) begin
      errors++; $display("FAIL single_end: tx=%b busy=%b pops=%0d want 1,0,1", TX_OUT, BUSY, pop_count - p0);
    end
  endtask

  task automatic test_parity();
    logic [7:0]  pd [3] = '{8'h03, 8'h03, 8'h07};
    logic        pt [3] = '{PAR_EVEN, PAR_ODD, PAR_EVEN};
    logic        pb [3] = '{1'b0, 1'b1, 1'b1};
    logic [11:0] bits; bit shape; int w; exp_t e;
    for (int i = 0; i < 3; i++) begin
      EN = 1'b1; PAR_EN = 1'b1; PAR_TYP = pt[i]; PRESCALE = 6'd2;
      push_word(pd[i], 1'b1, pt[i], 2);
      rx_frame(2, 11, bits, shape, w);
      e = sb.pop_front();
      checks++;
      if (bits[9] !== pb[i] || w >= 600) begin
        errors++; $display("FAIL parity_bit[%0d]: got %b want %b (wait %0d)", i, bits[9], pb[i], w);
      end
      checks++;
      if (bits !== exp_bits(e) || !shape) begin
        errors++; $display("FAIL parity_frame[%0d]: got %h shape=%b want %h", i, bits, shape, exp_bits(e));
      end
      @(negedge CLK);
      checks++;
      if ({TX_OUT, BUSY} !== 2'b10) begin
        errors++; $display("FAIL parity_end[%0d]: got %b want 10", i, {TX_OUT, BUSY});
      end
    end
  endtask

  task automatic test_prescale_zero();
    logic [11:0] bits; bit shape; int w; exp_t e;
    EN = 1'b1; PAR_EN = 1'b0; PRESCALE = 6'd0;
    push_word(8'h5A, 1'b0, PAR_EVEN, 1);
    rx_frame(1, 10, bits, shape, w);
    e = sb.pop_front();
    checks++;
    if (bits !== exp_bits(e) || !shape || w >= 600) begin
      errors++; $display("FAIL p0_frame: got %h shape=%b want %h", bits, shape, exp_bits(e));
    end
    @(negedge CLK);
    checks++;
    if ({TX_OUT, BUSY} !== 2'b10) begin
      errors++; $display("FAIL p0_length: got %b want 10 after 10 cycles", {TX_OUT, BUSY});
    end
  endtask

  task automatic test_midframe();
    logic [11:0] bits; bit shape; int w; int p0; exp_t e;
    EN = 1'b1; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN; PRESCALE = 6'd3;
    push_word(8'h96, 1'b0, PAR_EVEN, 3);
    fork
      rx_frame(3, 10, bits, shape, w);
      begin
        repeat (6) @(negedge CLK);
        PRESCALE = 6'd7; PAR_EN = 1'b1; PAR_TYP = PAR_ODD; EN = 1'b0;
      end
    join
    e = sb.pop_front();
    checks++;
    if (bits !== exp_bits(e) || !shape || w >= 600) begin
      errors++; $display("FAIL midframe_frame: got %h shape=%b want %h", bits, shape, exp_bits(e));
    end
    @(negedge CLK);
    checks++;
    if ({TX_OUT, BUSY} !== 2'b10) begin
      errors++; $display("FAIL midframe_end: got %b want 10", {TX_OUT, BUSY});
    end
    p0 = pop_count;
    push_word(8'h3C, 1'b1, PAR_ODD, 7);
    repeat (30) @(negedge CLK);
    checks++;
    if (pop_count != p0 || BUSY !== 1'b0 || TX_OUT !== 1'b1) begin
      errors++; $display("FAIL en_low_nopop: pops=%0d busy=%b tx=%b want 0,0,1", pop_count - p0, BUSY, TX_OUT);
    end
    EN = 1'b1;
    rx_frame(7, 11, bits, shape, w);
    e = sb.pop_front();
    checks++;
    if (bits !== exp_bits(e) || !shape || w >= 600) begin
      errors++; $display("FAIL en_resume_frame: got %h shape=%b want %h", bits, shape, exp_bits(e));
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic [11:0] bits; bit shape; int w; int p0; exp_t e;
    EN = 1'b1; PAR_EN = 1'b0; PRESCALE = 6'd1;
    p0 = pop_count;
    push_word(8'h11, 1'b0, PAR_EVEN, 1);
    push_word(8'h22, 1'b0, PAR_EVEN, 1);
    push_word(8'h33, 1'b0, PAR_EVEN, 1);
    for (int i = 0; i < 3; i++) begin
      rx_frame(1, 10, bits, shape, w);
      e = sb.pop_front();
      checks++;
      if (bits !== exp_bits(e) || !shape || w != 0) begin
        errors++; $display("FAIL b2b_frame[%0d]: got %h shape=%b gap=%0d want %h gap 0", i, bits, shape, w, exp_bits(e));
      end
      @(negedge CLK);
      checks++;
      if ({TX_OUT, BUSY} !== 2'b10) begin
        errors++; $display("FAIL b2b_idle[%0d]: got %b want 10", i, {TX_OUT, BUSY});
      end
    end
    checks++;
    if (pop_count - p0 != 3) begin
      errors++; $display("FAIL b2b_pops: got %0d want 3", pop_count - p0);
    end
  endtask

  task automatic test_integration();
    logic [11:0] bits; bit shape; int w; int p0; exp_t e;
    EN = 1'b0; PAR_EN = 1'b1; PAR_TYP = PAR_ODD; PRESCALE = 6'd2;
    p0 = pop_count;
    for (int i = 0; i < 8; i++) begin
      @(negedge WCLK);
      push_word(8'($urandom_range(0, 255)), 1'b1, PAR_ODD, 2);
    end
    @(negedge CLK);
    EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_frame(2, 11, bits, shape, w);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL integ_queue[%0d]: got empty queue want entry", i);
      end else begin
        e = sb.pop_front();
        if (bits !== exp_bits(e) || !shape || w >= 600) begin
          errors++; $display("FAIL integ_frame[%0d]: got %h shape=%b want %h", i, bits, shape, exp_bits(e));
        end
      end
    end
    repeat (20) @(negedge CLK);
    checks++;
    if (FIFO_EMPTY !== 1'b1 || BUSY !== 1'b0 || pop_count - p0 != 8) begin
      errors++; $display("FAIL integ_end: empty=%b busy=%b pops=%0d want 1,0,8", FIFO_EMPTY, BUSY, pop_count - p0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_prescale_zero();
    test_midframe();
    test_back_to_back();
    test_integration();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
